// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM channel arbiter.
package sdram_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_WAIT} arb_state_t;

  localparam int unsigned STARVE_W = 8;
  localparam logic [STARVE_W-1:0] STARVE_MAX = '1;

endpackage

// File: rtl/sdram_arb_select.sv
// Grant selection: lowest-index starved channel first, else lowest-index pending channel.
module sdram_arb_select #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned IDX_W  = 2
) (
  input  logic [NUM_CH-1:0] pending,
  input  logic [NUM_CH-1:0] starved,
  output logic              grant_valid,
  output logic [IDX_W-1:0]  grant_idx
);

  logic any_starved;

  always_comb begin
    any_starved = |starved;
    grant_valid = |pending;
    grant_idx   = '0;
    // Scan downward so the lowest qualifying index wins.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (any_starved ? starved[i] : pending[i]) grant_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/sdram_channel_arbiter.sv
// Shares one toggle-handshake SDRAM port between NUM_CH requesters with fixed
// priority plus a starvation guard.
module sdram_channel_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned ADDR_W       = 27,
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned STARVE_LIMIT = 6,
  localparam int unsigned IDX_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned BE_W        = DATA_W / 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        ch_req,
  output logic [NUM_CH-1:0]        ch_ack,
  input  logic [NUM_CH-1:0]        ch_rw,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
  input  logic [NUM_CH*BE_W-1:0]   ch_be,
  output logic [NUM_CH*DATA_W-1:0] ch_q,
  output logic [ADDR_W-1:0]        sdr_addr,
  output logic [DATA_W-1:0]        sdr_data,
  output logic [BE_W-1:0]          sdr_be,
  output logic                     sdr_rw,
  output logic                     sdr_req,
  input  logic                     sdr_ack,
  input  logic [DATA_W-1:0]        sdr_q,
  output logic                     busy,
  output logic [IDX_W-1:0]         active_ch
);

  arb_state_t state_q, state_d;

  logic [STARVE_W-1:0] starve_cnt [NUM_CH];
  logic [NUM_CH-1:0]   pending;
  logic [NUM_CH-1:0]   starved;
  logic                grant_valid;
  logic [IDX_W-1:0]    grant_idx;
  logic                grant_en;
  logic                done;
  logic                req_snap;

  assign pending = ch_req ^ ch_ack;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      starved[i] = pending[i] && (starve_cnt[i] >= STARVE_W'(STARVE_LIMIT));
    end
  end

  sdram_arb_select #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_select (
    .pending     (pending),
    .starved     (starved),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ARB_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: if (grant_valid) state_d = ARB_WAIT;
      ARB_WAIT: if (sdr_ack == sdr_req) state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    grant_en = (state_q == ARB_IDLE) && grant_valid;
    done     = (state_q == ARB_WAIT) && (sdr_ack == sdr_req);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) starve_cnt[i] <= '0;
      ch_ack    <= '0;
      ch_q      <= '0;
      sdr_addr  <= '0;
      sdr_data  <= '0;
      sdr_be    <= '0;
      sdr_rw    <= 1'b0;
      sdr_req   <= 1'b0;
      busy      <= 1'b0;
      active_ch <= '0;
      req_snap  <= 1'b0;
    end else if (grant_en) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (IDX_W'(i) == grant_idx)  starve_cnt[i] <= '0;
        else if (pending[i])         starve_cnt[i] <= (starve_cnt[i] == STARVE_MAX) ?
                                                      starve_cnt[i] : starve_cnt[i] + 1'b1;
        else                         starve_cnt[i] <= '0;
      end
      sdr_addr  <= ch_addr[grant_idx*ADDR_W +: ADDR_W];
      sdr_data  <= ch_wdata[grant_idx*DATA_W +: DATA_W];
      sdr_be    <= ch_be[grant_idx*BE_W +: BE_W];
      sdr_rw    <= ch_rw[grant_idx];
      sdr_req   <= ~sdr_req;
      req_snap  <= ch_req[grant_idx];
      active_ch <= grant_idx;
      busy      <= 1'b1;
    end else if (done) begin
      if (sdr_rw) ch_q[active_ch*DATA_W +: DATA_W] <= sdr_q;
      // Ack with the snapshot so a mid-flight re-toggle stays pending.
      ch_ack[active_ch] <= req_snap;
      busy              <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sdram_channel_arbiter.sv
// Scoreboard bench for sdram_channel_arbiter: a transaction-level model predicts
// every issue and completion; a monitor compares what the DUT presents.
module tb_sdram_channel_arbiter;

  localparam int unsigned NUM_CH = 4, ADDR_W = 27, DATA_W = 64, STARVE_LIMIT = 6;
  localparam int unsigned BE_W = DATA_W / 8, IDX_W = 2;

  logic                     clk, reset;
  logic [NUM_CH-1:0]        ch_req, ch_ack, ch_rw;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH*DATA_W-1:0] ch_wdata, ch_q;
  logic [NUM_CH*BE_W-1:0]   ch_be;
  logic [ADDR_W-1:0]        sdr_addr;
  logic [DATA_W-1:0]        sdr_data, sdr_q;
  logic [BE_W-1:0]          sdr_be;
  logic                     sdr_rw, sdr_req, sdr_ack, busy;
  logic [IDX_W-1:0]         active_ch;

  sdram_channel_arbiter #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .reset(reset), .ch_req(ch_req), .ch_ack(ch_ack), .ch_rw(ch_rw),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_be(ch_be), .ch_q(ch_q),
    .sdr_addr(sdr_addr), .sdr_data(sdr_data), .sdr_be(sdr_be), .sdr_rw(sdr_rw),
    .sdr_req(sdr_req), .sdr_ack(sdr_ack), .sdr_q(sdr_q), .busy(busy), .active_ch(active_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int unsigned tag; int ch; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data;
    logic [BE_W-1:0] be; logic rw;
  } iss_t;
  typedef struct { int unsigned tag; int ch; logic [DATA_W-1:0] q; } cpl_t;

  iss_t iss_q[$];
  cpl_t cpl_q[$];
  int   grant_log[$];

  // Reference model state (transaction view of the arbiter).
  bit                m_busy;
  int                m_active;
  logic              m_snap, m_sreq, m_rw;
  logic [NUM_CH-1:0] m_ack;
  int                m_cnt [NUM_CH];
  logic [DATA_W-1:0] m_q [NUM_CH];

  int errors = 0, checks = 0;
  int ctl_wait;
  bit ctl_stall;
  logic [DATA_W-1:0] ctl_q;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event/timeout expected none", name);
  endtask

  task automatic model_reset();
    m_busy = 0; m_active = 0; m_snap = 0; m_sreq = 0; m_rw = 0; m_ack = '0;
    for (int i = 0; i < NUM_CH; i++) begin m_cnt[i] = 0; m_q[i] = '0; end
  endtask

  task automatic new_request(input int i, input logic rw, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] data, input logic [BE_W-1:0] be);
    ch_req[i] = ~ch_req[i];
    ch_rw[i]  = rw;
    ch_addr[i*ADDR_W +: ADDR_W] = addr;
    ch_wdata[i*DATA_W +: DATA_W] = data;
    ch_be[i*BE_W +: BE_W] = be;
  endtask

  task automatic rand_request(input int i);
    new_request(i, 1'($urandom_range(0, 1)), ADDR_W'($urandom), {$urandom, $urandom},
                BE_W'($urandom));
  endtask

  // Controller: acks the model's outstanding request after a random delay.
  task automatic ctl_update();
    if (m_busy && sdr_ack != m_sreq && !ctl_stall) begin
      if (ctl_wait == 0) begin
        sdr_ack  = m_sreq;
        sdr_q    = ctl_q;
        ctl_q    = {$urandom, $urandom};
        ctl_wait = $urandom_range(0, 3);
      end else ctl_wait--;
    end
  endtask

  // Predicts what the next clock edge does, from the current inputs.
  task automatic model_eval();
    int g = -1;
    logic [NUM_CH-1:0] pend = ch_req ^ m_ack;
    iss_t e;
    cpl_t c;
    if (!m_busy) begin
      for (int i = 0; i < NUM_CH; i++) if (g < 0 && pend[i] && m_cnt[i] >= STARVE_LIMIT) g = i;
      for (int i = 0; i < NUM_CH; i++) if (g < 0 && pend[i]) g = i;
      if (g >= 0) begin
        e.tag = edge_cnt + 1; e.ch = g; e.rw = ch_rw[g];
        e.addr = ch_addr[g*ADDR_W +: ADDR_W];
        e.data = ch_wdata[g*DATA_W +: DATA_W];
        e.be = ch_be[g*BE_W +: BE_W];
        iss_q.push_back(e);
        for (int i = 0; i < NUM_CH; i++)
          m_cnt[i] = (i == g || !pend[i]) ? 0 : (m_cnt[i] < 255 ? m_cnt[i] + 1 : 255);
        m_sreq = ~m_sreq; m_snap = ch_req[g]; m_active = g; m_rw = ch_rw[g]; m_busy = 1;
      end
    end else if (sdr_ack == m_sreq) begin
      if (m_rw) m_q[m_active] = sdr_q;
      m_ack[m_active] = m_snap;
      c.tag = edge_cnt + 1; c.ch = m_active; c.q = m_q[m_active];
      cpl_q.push_back(c);
      m_busy = 0;
    end
  endtask

  task automatic cycle();
    ctl_update();
    model_eval();
    @(negedge clk);
  endtask

  task automatic rnd_stim();
    for (int i = 0; i < NUM_CH; i++) begin
      if (!(ch_req[i] ^ m_ack[i])) begin
        if ($urandom_range(0, 3) == 0) rand_request(i);
      end else if (m_busy && m_active == i && ch_req[i] == m_snap) begin
        if ($urandom_range(0, 7) == 0) rand_request(i);
      end
    end
  endtask

  // Channels 0 and 1 re-request continuously, including mid-flight.
  task automatic starve_stim();
    for (int i = 0; i < 2; i++)
      if (!(ch_req[i] ^ m_ack[i]) || (m_busy && m_active == i && ch_req[i] == m_snap))
        rand_request(i);
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (k < 200 && (m_busy || (ch_req ^ m_ack) != '0)) begin cycle(); k++; end
    if (k >= 200) fail_evt({name, "_drain_timeout"});
    repeat (2) cycle();
  endtask

  task automatic wait_busy(input int ch, input string name);
    int k = 0;
    while (k < 20 && !(m_busy && m_active == ch)) begin cycle(); k++; end
    if (k >= 20) fail_evt({name, "_grant_timeout"});
  endtask

  task automatic do_reset();
    chk("queues_empty_at_reset", 256'(iss_q.size() + cpl_q.size()), 256'd0);
    iss_q.delete(); cpl_q.delete();
    reset = 1'b1; ch_req = '0; sdr_ack = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: compares DUT events and state against the model's predictions.
  initial begin
    logic prev_sreq = 1'b0;
    logic [NUM_CH-1:0] prev_ack = '0;
    logic [NUM_CH*DATA_W-1:0] exp_q;
    iss_t e;
    cpl_t c;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        chk("reset_sdr_req", 256'(sdr_req), 256'd0);
        chk("reset_busy", 256'(busy), 256'd0);
        chk("reset_ch_ack", 256'(ch_ack), 256'd0);
        chk("reset_ch_q", 256'(ch_q), 256'd0);
        chk("reset_active_ch", 256'(active_ch), 256'd0);
        chk("reset_sdr_addr", 256'(sdr_addr), 256'd0);
      end else begin
        if (sdr_req !== prev_sreq) begin
          if (iss_q.size() == 0) fail_evt("unexpected_issue");
          else begin
            e = iss_q.pop_front();
            grant_log.push_back(int'(active_ch));
            chk("issue_cycle", 256'(edge_cnt), 256'(e.tag));
            chk("issue_ch", 256'(active_ch), 256'(e.ch));
            chk("issue_addr", 256'(sdr_addr), 256'(e.addr));
            chk("issue_data", 256'(sdr_data), 256'(e.data));
            chk("issue_be", 256'(sdr_be), 256'(e.be));
            chk("issue_rw", 256'(sdr_rw), 256'(e.rw));
          end
        end
        if (ch_ack !== prev_ack) begin
          if (cpl_q.size() == 0) fail_evt("unexpected_ack");
          else begin
            c = cpl_q.pop_front();
            chk("ack_cycle", 256'(edge_cnt), 256'(c.tag));
            chk("ack_bit", 256'(ch_ack ^ prev_ack), 256'(1 << c.ch));
            chk("ack_q", 256'(ch_q[c.ch*DATA_W +: DATA_W]), 256'(c.q));
          end
        end
        if (iss_q.size() > 0 && iss_q[0].tag <= edge_cnt) begin
          fail_evt("missed_issue");
          void'(iss_q.pop_front());
        end
        if (cpl_q.size() > 0 && cpl_q[0].tag <= edge_cnt) begin
          fail_evt("missed_ack");
          void'(cpl_q.pop_front());
        end
        chk("busy", 256'(busy), 256'(m_busy));
        for (int i = 0; i < NUM_CH; i++) exp_q[i*DATA_W +: DATA_W] = m_q[i];
        chk("ch_q_all", 256'(ch_q), 256'(exp_q));
      end
      prev_sreq = sdr_req;
      prev_ack  = ch_ack;
    end
  end

  initial begin
    int exp_order[3] = '{0, 1, 3};
    bit ch3_seen;
    reset = 1'b1; ch_req = '0; ch_rw = '0; ch_addr = '0; ch_wdata = '0; ch_be = '0;
    sdr_ack = 1'b0; sdr_q = '0; ctl_wait = 0; ctl_stall = 0; ctl_q = '0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // Single read on channel 2.
    ctl_q = 64'hDEADBEEF_01234567;
    new_request(2, 1'b1, 27'h100, '0, '0);
    repeat (6) cycle();
    chk("single_read_q", 256'(ch_q[2*DATA_W +: DATA_W]), 256'h0DEADBEEF_01234567);
    chk("single_read_ack", 256'(ch_ack[2]), 256'd1);

    // Simultaneous requests on 0, 1, 3.
    grant_log.delete();
    for (int i = 0; i < NUM_CH; i++) if (i != 2) rand_request(i);
    repeat (30) cycle();
    chk("prio_grant_count", 256'(grant_log.size()), 256'd3);
    for (int k = 0; k < grant_log.size() && k < 3; k++)
      chk("prio_order", 256'(grant_log[k]), 256'(exp_order[k]));

    // Byte-enabled write on channel 1.
    new_request(1, 1'b0, 27'h2A0, {16{4'hA}}, 8'h0F);
    repeat (10) cycle();

    // Re-toggle channel 0 while its first request is in flight.
    rand_request(0);
    wait_busy(0, "retoggle");
    rand_request(0);
    repeat (20) cycle();

    // Starvation: 0 and 1 always busy, 3 must still get through.
    grant_log.delete();
    rand_request(3);
    for (int k = 0; k < 60; k++) begin starve_stim(); cycle(); end
    drain("starve");
    ch3_seen = 0;
    foreach (grant_log[k]) if (grant_log[k] == 3) ch3_seen = 1;
    chk("starve_ch3_served", 256'(ch3_seen), 256'd1);

    // Reset while waiting on the controller.
    ctl_stall = 1;
    rand_request(2);
    wait_busy(2, "reset_wait");
    do_reset();
    ctl_stall = 0; ctl_wait = 0;
    new_request(2, 1'b1, 27'h300, '0, '0);
    repeat (10) cycle();
    chk("post_reset_ack", 256'(ch_ack[2]), 256'd1);

    // Random traffic.
    repeat (3000) begin rnd_stim(); cycle(); end
    drain("random");
    chk("final_queues_empty", 256'(iss_q.size() + cpl_q.size()), 256'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
